// File: rtl/cache_axi_pkg.sv
// Shared types and AXI field constants for the cache-to-AXI arbiter.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_D_AR   = 3'd1,
    R_D_DATA = 3'd2,
    R_I_AR   = 3'd3,
    R_I_DATA = 3'd4
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam int         LINE_OFF_W     = 5;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Bundle of the i-cache, d-cache and AXI4 master signals around the arbiter.
// master = arbiter view, slave = the surrounding caches and crossbar.
interface cache_axi_arbiter_if #(parameter int ID_W = 4);

  logic [31:0]     i_araddr;
  logic [7:0]      i_arlen;
  logic            i_arvalid;
  logic            i_arready;
  logic [31:0]     i_rdata;
  logic            i_rlast;
  logic            i_rvalid;
  logic            i_rready;

  logic [31:0]     d_araddr;
  logic [7:0]      d_arlen;
  logic [2:0]      d_arsize;
  logic            d_arvalid;
  logic            d_arready;
  logic [31:0]     d_rdata;
  logic            d_rlast;
  logic            d_rvalid;
  logic            d_rready;

  logic [31:0]     d_awaddr;
  logic [7:0]      d_awlen;
  logic            d_awvalid;
  logic            d_awready;
  logic [31:0]     d_wdata;
  logic [3:0]      d_wstrb;
  logic            d_wlast;
  logic            d_wvalid;
  logic            d_wready;
  logic            d_bvalid;
  logic            d_bready;

  logic [ID_W-1:0] m_arid;
  logic [31:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [ID_W-1:0] m_rid;
  logic [31:0]     m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
  logic [ID_W-1:0] m_awid;
  logic [31:0]     m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic            m_awvalid;
  logic            m_awready;
  logic [ID_W-1:0] m_wid;
  logic [31:0]     m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_wlast;
  logic            m_wvalid;
  logic            m_wready;
  logic [ID_W-1:0] m_bid;
  logic [1:0]      m_bresp;
  logic            m_bvalid;
  logic            m_bready;

  modport master (
    input  i_araddr, i_arlen, i_arvalid, i_rready,
    input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    input  d_awaddr, d_awlen, d_awvalid, d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_awready, m_wready, m_bid, m_bresp, m_bvalid,
    output i_arready, i_rdata, i_rlast, i_rvalid,
    output d_arready, d_rdata, d_rlast, d_rvalid, d_awready, d_wready, d_bvalid,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
  );

  modport slave (
    output i_araddr, i_arlen, i_arvalid, i_rready,
    output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    output d_awaddr, d_awlen, d_awvalid, d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_awready, m_wready, m_bid, m_bresp, m_bvalid,
    input  i_arready, i_rdata, i_rlast, i_rvalid,
    input  d_arready, d_rdata, d_rlast, d_rvalid, d_awready, d_wready, d_bvalid,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
  );

endinterface

// File: rtl/cache_axi_arbiter.sv
// Serialises i-cache and d-cache read bursts onto one AXI4 master and passes d-cache writes through.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both caches request at once.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int I_ID = 0,
  parameter int D_ID = 1
) (
  input logic clk,
  input logic rst,
  cache_axi_arbiter_if.master bus
);

  localparam logic [ID_W-1:0] I_ID_V = ID_W'(I_ID);
  localparam logic [ID_W-1:0] D_ID_V = ID_W'(D_ID);

  rd_state_t                state;
  logic                     wr_pend;
  logic [31:LINE_OFF_W]     wr_line;
  logic                     d_blocked;
  logic                     d_req;
  logic                     i_req;
  logic                     pick_d;
  logic                     ar_fire;
  logic                     r_done;
  logic                     aw_fire;
  logic                     b_fire;
  logic                     unused_resp;

  // A d-cache read may not overtake a write still in flight to the same cache line.
  assign d_blocked = wr_pend && (bus.d_araddr[31:LINE_OFF_W] == wr_line);
  assign d_req     = bus.d_arvalid && !d_blocked;
  assign i_req     = bus.i_arvalid;
  assign ar_fire   = bus.m_arvalid && bus.m_arready;
  assign r_done    = bus.m_rvalid && bus.m_rready && bus.m_rlast;
  assign aw_fire   = bus.m_awvalid && bus.m_awready;
  assign b_fire    = bus.m_bvalid && bus.m_bready;

  assign unused_resp = ^{bus.m_rid, bus.m_rresp, bus.m_bid, bus.m_bresp};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // last_grant is 1 when the i-cache owned the most recent completed burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (r_done && state == R_D_DATA) begin
      last_grant <= 1'b0;
    end else if (r_done && state == R_I_DATA) begin
      last_grant <= 1'b1;
    end
  end

  assign pick_d = d_req && (!i_req || last_grant);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= R_IDLE;
    end else begin
      case (state)
        R_IDLE: begin
          if (pick_d) begin
            state <= R_D_AR;
          end else if (i_req) begin
            state <= R_I_AR;
          end
        end
        R_D_AR:   if (ar_fire) state <= R_D_DATA;
        R_I_AR:   if (ar_fire) state <= R_I_DATA;
        R_D_DATA: if (r_done)  state <= R_IDLE;
        R_I_DATA: if (r_done)  state <= R_IDLE;
        default:               state <= R_IDLE;
      endcase
    end
  end

  // Only the granted cache sees AR ready and R traffic; everything idles at zero.
  always_comb begin
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arsize  = '0;
    bus.m_arburst = '0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.i_arready = 1'b0;
    bus.i_rdata   = '0;
    bus.i_rlast   = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_arready = 1'b0;
    bus.d_rdata   = '0;
    bus.d_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    case (state)
      R_D_AR: begin
        bus.m_arid    = D_ID_V;
        bus.m_araddr  = bus.d_araddr;
        bus.m_arlen   = bus.d_arlen;
        bus.m_arsize  = bus.d_arsize;
        bus.m_arburst = AXI_BURST_INCR;
        bus.m_arvalid = bus.d_arvalid;
        bus.d_arready = bus.m_arready;
      end
      R_I_AR: begin
        bus.m_arid    = I_ID_V;
        bus.m_araddr  = bus.i_araddr;
        bus.m_arlen   = bus.i_arlen;
        bus.m_arsize  = AXI_SIZE_WORD;
        bus.m_arburst = AXI_BURST_INCR;
        bus.m_arvalid = bus.i_arvalid;
        bus.i_arready = bus.m_arready;
      end
      R_D_DATA: begin
        bus.d_rdata  = bus.m_rdata;
        bus.d_rlast  = bus.m_rlast;
        bus.d_rvalid = bus.m_rvalid;
        bus.m_rready = bus.d_rready;
      end
      R_I_DATA: begin
        bus.i_rdata  = bus.m_rdata;
        bus.i_rlast  = bus.m_rlast;
        bus.i_rvalid = bus.m_rvalid;
        bus.m_rready = bus.i_rready;
      end
      default: begin
      end
    endcase
  end

  assign bus.m_awid    = D_ID_V;
  assign bus.m_awaddr  = bus.d_awaddr;
  assign bus.m_awlen   = bus.d_awlen;
  assign bus.m_awsize  = AXI_SIZE_WORD;
  assign bus.m_awburst = AXI_BURST_INCR;
  assign bus.m_awvalid = bus.d_awvalid & ~rst;
  assign bus.d_awready = bus.m_awready & ~rst;
  assign bus.m_wid     = D_ID_V;
  assign bus.m_wdata   = bus.d_wdata;
  assign bus.m_wstrb   = bus.d_wstrb;
  assign bus.m_wlast   = bus.d_wlast;
  assign bus.m_wvalid  = bus.d_wvalid & ~rst;
  assign bus.d_wready  = bus.m_wready & ~rst;
  assign bus.d_bvalid  = bus.m_bvalid & ~rst;
  assign bus.m_bready  = bus.d_bready & ~rst;

  // A new AW in the same cycle as a B keeps the pending flag set for the new write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend <= 1'b0;
      wr_line <= '0;
    end else if (aw_fire) begin
      wr_pend <= 1'b1;
      wr_line <= bus.d_awaddr[31:LINE_OFF_W];
    end else if (b_fire) begin
      wr_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter: directed cache traffic against a simple AXI slave model.
module tb_cache_axi_arbiter;
  import cache_axi_pkg::*;

  localparam int ID_W  = 4;
  localparam int I_ID  = 0;
  localparam int D_ID  = 1;
  localparam int BOUND = 2000;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  bit   rv_toggle = 1'b0;

  ar_t         ar_exp[$];
  ar_t         slv_q[$];
  aw_t         aw_exp[$];
  logic [32:0] d_exp[$];
  logic [32:0] i_exp[$];
  logic [36:0] w_exp[$];
  int          d_last_cyc = 0;
  int          ar_cyc_i = 0;
  int          ar_cyc_d = 0;
  int          b_cyc = 0;

  cache_axi_arbiter_if #(.ID_W(ID_W)) bus ();

  cache_axi_arbiter #(.ID_W(ID_W), .I_ID(I_ID), .D_ID(D_ID)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] beat_data(input logic [31:0] addr, input int k);
    return addr ^ (32'hA500_0000 + 32'(k));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  function automatic void expect_read(input bit is_d, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [2:0] size);
    ar_t e;
    e.id   = is_d ? 4'(D_ID) : 4'(I_ID);
    e.addr = addr;
    e.len  = len;
    e.size = size;
    ar_exp.push_back(e);
    for (int k = 0; k <= int'(len); k++) begin
      if (is_d) d_exp.push_back({k == int'(len), beat_data(addr, k)});
      else      i_exp.push_back({k == int'(len), beat_data(addr, k)});
    end
  endfunction

  function automatic bit fire(input int which);
    case (which)
      0:       return bus.i_arvalid && bus.i_arready;
      1:       return bus.d_arvalid && bus.d_arready;
      2:       return bus.d_awvalid && bus.d_awready;
      3:       return bus.d_wvalid && bus.d_wready;
      default: return bus.m_bvalid && bus.m_bready;
    endcase
  endfunction

  // Called right after driving at a negedge; returns at the negedge following the handshake.
  task automatic wait_fire(input int which, input string name);
    int n = 0;
    #4;
    while (!fire(which) && n < BOUND) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!fire(which)) flag(name, "handshake timed out");
    @(negedge clk);
  endtask

  task automatic applyStimulus_read(input bit is_d, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [2:0] size);
    @(negedge clk);
    if (is_d) begin
      bus.d_araddr  = addr;
      bus.d_arlen   = len;
      bus.d_arsize  = size;
      bus.d_arvalid = 1'b1;
      wait_fire(1, "d_ar");
      bus.d_arvalid = 1'b0;
    end else begin
      bus.i_araddr  = addr;
      bus.i_arlen   = len;
      bus.i_arvalid = 1'b1;
      wait_fire(0, "i_ar");
      bus.i_arvalid = 1'b0;
    end
  endtask

  task automatic applyStimulus_write(input logic [31:0] addr, input int beats, input logic [31:0] seed);
    aw_t a;
    a.addr = addr;
    a.len  = 8'(beats - 1);
    aw_exp.push_back(a);
    for (int k = 0; k < beats; k++) w_exp.push_back({seed + 32'(k), 4'hF, k == beats - 1});
    @(negedge clk);
    bus.d_awaddr  = addr;
    bus.d_awlen   = 8'(beats - 1);
    bus.d_awvalid = 1'b1;
    wait_fire(2, "d_aw");
    bus.d_awvalid = 1'b0;
    for (int k = 0; k < beats; k++) begin
      bus.d_wdata  = seed + 32'(k);
      bus.d_wstrb  = 4'hF;
      bus.d_wlast  = (k == beats - 1);
      bus.d_wvalid = 1'b1;
      wait_fire(3, "d_w");
    end
    bus.d_wvalid = 1'b0;
  endtask

  task automatic send_b();
    @(negedge clk);
    bus.m_bvalid = 1'b1;
    wait_fire(4, "m_b");
    bus.m_bvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((ar_exp.size() + d_exp.size() + i_exp.size() + aw_exp.size() + w_exp.size()) != 0
           && n < BOUND) begin
      @(negedge clk);
      #4;
      n++;
    end
    if ((ar_exp.size() + d_exp.size() + i_exp.size() + aw_exp.size() + w_exp.size()) != 0)
      flag(name, "expected traffic never arrived");
  endtask

  // AXI slave: accepts every AR, then returns its beats in order.
  initial begin
    bus.m_arready = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.m_arvalid && bus.m_arready)
        slv_q.push_back('{bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize});
    end
  end

  initial begin
    ar_t cur;
    int  beat = 0;
    bit  active = 1'b0;
    bit  tog = 1'b0;
    cur = '0;
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_rdata  = 32'hDEAD_BEEF;
    bus.m_rid    = '0;
    bus.m_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (!active && slv_q.size() > 0) begin
        cur    = slv_q.pop_front();
        beat   = 0;
        active = 1'b1;
      end
      tog = ~tog;
      bus.m_rvalid = active && (!rv_toggle || tog);
      bus.m_rdata  = active ? beat_data(cur.addr, beat) : 32'hDEAD_BEEF;
      bus.m_rlast  = active && (beat == int'(cur.len));
      bus.m_rid    = cur.id;
      #4;
      if (bus.m_rvalid && bus.m_rready) begin
        if (beat == int'(cur.len)) active = 1'b0;
        beat++;
      end
    end
  end

  task automatic checkOutput();
    ar_t         e;
    aw_t         a;
    logic [32:0] r;
    logic [36:0] w;
    if (bus.m_arvalid && bus.m_arready) begin
      if (ar_exp.size() == 0) flag("ar", "unexpected AR");
      else begin
        e = ar_exp.pop_front();
        check("ar_fields", 64'({bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize}), 64'(e));
        check("ar_burst", 64'(bus.m_arburst), 64'(2'b01));
        if (bus.m_arid == 4'(D_ID)) ar_cyc_d = cyc;
        else ar_cyc_i = cyc;
      end
    end
    if (bus.d_rvalid && bus.d_rready) begin
      if (d_exp.size() == 0) flag("d_beat", "unexpected beat");
      else begin
        r = d_exp.pop_front();
        check("d_beat", 64'({bus.d_rlast, bus.d_rdata}), 64'(r));
        check("i_quiet", 64'(bus.i_rvalid), 64'(0));
        if (bus.d_rlast) d_last_cyc = cyc;
      end
    end
    if (bus.i_rvalid && bus.i_rready) begin
      if (i_exp.size() == 0) flag("i_beat", "unexpected beat");
      else begin
        r = i_exp.pop_front();
        check("i_beat", 64'({bus.i_rlast, bus.i_rdata}), 64'(r));
        check("d_quiet", 64'(bus.d_rvalid), 64'(0));
      end
    end
    if (bus.m_awvalid && bus.m_awready) begin
      if (aw_exp.size() == 0) flag("aw", "unexpected AW");
      else begin
        a = aw_exp.pop_front();
        check("aw_fields",
              64'({bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst}),
              64'({4'(D_ID), a.addr, a.len, 3'd2, 2'b01}));
      end
    end
    if (bus.m_wvalid && bus.m_wready) begin
      if (w_exp.size() == 0) flag("w", "unexpected W beat");
      else begin
        w = w_exp.pop_front();
        check("w_beat", 64'({bus.m_wid, bus.m_wdata, bus.m_wstrb, bus.m_wlast}),
              64'({4'(D_ID), w}));
      end
    end
    if (bus.m_bvalid && bus.m_bready) begin
      check("b_pass", 64'(bus.d_bvalid), 64'(1));
      b_cyc = cyc;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) checkOutput();
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arvalid = 1'b0; bus.i_rready = 1'b1;
    bus.d_araddr = '0; bus.d_arlen = '0; bus.d_arsize = 3'd2; bus.d_rready = 1'b1;
    bus.d_awaddr = '0; bus.d_awlen = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.d_wlast = 1'b0; bus.d_wvalid = 1'b0; bus.d_bready = 1'b1;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    bus.m_bid = '0; bus.m_bresp = 2'b00;
    bus.d_arvalid = 1'b1;
    bus.d_awvalid = 1'b1;
    bus.m_bvalid  = 1'b1;

    // Reset: requests and responses are present but everything must stay quiet.
    repeat (3) @(negedge clk);
    #4;
    check("rst_m_arvalid", 64'(bus.m_arvalid), 64'(0));
    check("rst_d_arready", 64'(bus.d_arready), 64'(0));
    check("rst_m_awvalid", 64'(bus.m_awvalid), 64'(0));
    check("rst_d_awready", 64'(bus.d_awready), 64'(0));
    check("rst_d_wready",  64'(bus.d_wready),  64'(0));
    check("rst_d_bvalid",  64'(bus.d_bvalid),  64'(0));
    check("rst_m_bready",  64'(bus.m_bready),  64'(0));
    check("rst_m_rready",  64'(bus.m_rready),  64'(0));
    check("rst_d_rdata",   64'(bus.d_rdata),   64'(0));
    check("rst_i_rvalid",  64'(bus.i_rvalid),  64'(0));
    @(negedge clk);
    bus.d_arvalid = 1'b0;
    bus.d_awvalid = 1'b0;
    bus.m_bvalid  = 1'b0;
    rst = 1'b0;

    // Single d-cache burst; the grant is registered so AR cannot appear in the request cycle.
    expect_read(1'b1, 32'h1000_0020, 8'd7, 3'd2);
    fork
      applyStimulus_read(1'b1, 32'h1000_0020, 8'd7, 3'd2);
      begin
        @(negedge clk);
        #4;
        check("ar_registered", 64'(bus.m_arvalid), 64'(0));
      end
    join
    wait_drain("t1_drain");
    @(negedge clk);
    #4;
    check("idle_m_rready", 64'(bus.m_rready), 64'(0));
    check("idle_d_rdata",  64'(bus.d_rdata),  64'(0));

    // Simultaneous requests: d-cache first, i-cache AR after one idle cycle.
    expect_read(1'b1, 32'h1000_1000, 8'd3, 3'd2);
    expect_read(1'b0, 32'h2000_1000, 8'd3, 3'd2);
    fork
      applyStimulus_read(1'b1, 32'h1000_1000, 8'd3, 3'd2);
      applyStimulus_read(1'b0, 32'h2000_1000, 8'd3, 3'd2);
    join
    wait_drain("t2_drain");
    check("t2_i_after_rlast", 64'(ar_cyc_i - d_last_cyc), 64'(2));

    // Pending write to the same line holds the d-cache read until B.
    applyStimulus_write(32'h2000_0040, 1, 32'h1111_0000);
    expect_read(1'b0, 32'h6000_0000, 8'd3, 3'd2);
    expect_read(1'b1, 32'h2000_0050, 8'd3, 3'd2);
    fork
      applyStimulus_read(1'b1, 32'h2000_0050, 8'd3, 3'd2);
      applyStimulus_read(1'b0, 32'h6000_0000, 8'd3, 3'd2);
      begin
        for (int c = 0; c < BOUND && i_exp.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        send_b();
      end
    join
    wait_drain("t3_drain");
    check("t3_ar_after_b", 64'(ar_cyc_d - b_cyc), 64'(2));

    // Write and unrelated read overlap.
    expect_read(1'b1, 32'h4000_0000, 8'd3, 3'd2);
    fork
      applyStimulus_write(32'h3000_0000, 2, 32'hCAFE_0000);
      applyStimulus_read(1'b1, 32'h4000_0000, 8'd3, 3'd2);
    join
    wait_drain("t4_drain");
    send_b();

    // Gappy R channel with i-cache backpressure.
    rv_toggle = 1'b1;
    expect_read(1'b0, 32'h5000_0100, 8'd5, 3'd2);
    fork
      applyStimulus_read(1'b0, 32'h5000_0100, 8'd5, 3'd2);
      begin
        for (int c = 0; c < BOUND && i_exp.size() != 0; c++) begin
          @(negedge clk);
          bus.i_rready = ((c % 4) < 2);
        end
        bus.i_rready = 1'b1;
      end
    join
    wait_drain("t5_drain");
    rv_toggle = 1'b0;

    // Both caches keep requesting; the i-cache owned the last burst.
`ifdef ARB_ROUND_ROBIN_EN
    expect_read(1'b1, 32'h7000_0000, 8'd3, 3'd2);
    expect_read(1'b0, 32'h7100_0000, 8'd3, 3'd2);
    expect_read(1'b1, 32'h7000_0100, 8'd3, 3'd2);
    expect_read(1'b0, 32'h7100_0100, 8'd3, 3'd2);
    expect_read(1'b1, 32'h7000_0200, 8'd3, 3'd2);
`else
    expect_read(1'b1, 32'h7000_0000, 8'd3, 3'd2);
    expect_read(1'b1, 32'h7000_0100, 8'd3, 3'd2);
    expect_read(1'b1, 32'h7000_0200, 8'd3, 3'd2);
    expect_read(1'b0, 32'h7100_0000, 8'd3, 3'd2);
    expect_read(1'b0, 32'h7100_0100, 8'd3, 3'd2);
`endif
    fork
      begin
        for (int k = 0; k < 3; k++)
          applyStimulus_read(1'b1, 32'h7000_0000 + 32'(k * 256), 8'd3, 3'd2);
      end
      begin
        for (int k = 0; k < 2; k++)
          applyStimulus_read(1'b0, 32'h7100_0000 + 32'(k * 256), 8'd3, 3'd2);
      end
    join
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
